// File: rtl/gdma_rx_pkt_checker_if.sv
// ---------------------------------------------------------------------------
// gdma_rx_pkt_checker_if: 32-bit port2gdma AXI-Stream (valid/ready/data).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface gdma_rx_pkt_checker_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

`default_nettype wire

// File: rtl/gdma_rx_pkt_checker.sv
// ---------------------------------------------------------------------------
// gdma_rx_pkt_checker: sinks one port2gdma packet and checks it against seed+k.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gdma_rx_pkt_checker #(
    parameter int                LEN_W   = 8,
    parameter int                TMO_W   = 16,
    parameter logic [TMO_W-1:0]  TMO_CYC = 16'hFFFF
) (
    input  wire logic              gdma_clk,
    input  wire logic              rst_n,
    input  wire logic              start_i,
    input  wire logic [LEN_W-1:0]  pkt_len_i,
    input  wire logic [31:0]       seed_i,
    input  wire logic              throttle_i,
    gdma_rx_pkt_checker_if.slave   s_axis,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic                   timeout_o,
    output logic [15:0]            err_cnt_o,
    output logic [LEN_W-1:0]       word_cnt_o,
    output logic [LEN_W-1:0]       first_err_idx_o,
    output logic [31:0]            first_err_data_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   pkt_len_q;
    logic [31:0]        seed_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic               toggle_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic               timeout_q;
    logic [15:0]        err_cnt_q;
    logic [LEN_W-1:0]   word_cnt_q;
    logic [LEN_W-1:0]   first_err_idx_q;
    logic [31:0]        first_err_data_q;

    logic               w_hs;
    logic [31:0]        w_exp_data;
    logic               w_mismatch;
    logic               w_last_word;
    logic               w_tmo_hit;
    logic [15:0]        err_cnt_d;

    // Ready depends only on registered state and the throttle strap, never on tvalid.
    assign s_axis.tready = (state_q == RUN) && (!throttle_i || !toggle_q);

    assign w_hs        = s_axis.tvalid && s_axis.tready;
    assign w_exp_data  = seed_q + 32'(word_cnt_q);
    assign w_mismatch  = w_hs && (s_axis.tdata != w_exp_data);
    assign w_last_word = (word_cnt_q == pkt_len_q - LEN_W'(1));
    assign w_tmo_hit   = (tmo_cnt_q == TMO_CYC - TMO_W'(1));
    assign err_cnt_d   = (w_mismatch && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;

    always_ff @(posedge gdma_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            pkt_len_q        <= '0;
            seed_q           <= '0;
            tmo_cnt_q        <= '0;
            toggle_q         <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            err_cnt_q        <= '0;
            word_cnt_q       <= '0;
            first_err_idx_q  <= '0;
            first_err_data_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        pkt_len_q        <= pkt_len_i;
                        seed_q           <= seed_i;
                        tmo_cnt_q        <= '0;
                        toggle_q         <= 1'b0;
                        timeout_q        <= 1'b0;
                        err_cnt_q        <= '0;
                        word_cnt_q       <= '0;
                        first_err_idx_q  <= '0;
                        first_err_data_q <= '0;
                        if (pkt_len_i == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    toggle_q <= ~toggle_q;
                    if (w_hs) begin
                        err_cnt_q  <= err_cnt_d;
                        word_cnt_q <= word_cnt_q + LEN_W'(1);
                        tmo_cnt_q  <= '0;
                        if (w_mismatch && (err_cnt_q == 16'd0)) begin
                            first_err_idx_q  <= word_cnt_q;
                            first_err_data_q <= s_axis.tdata;
                        end
                        // A final handshake takes priority over a coincident stall expiry.
                        if (w_last_word) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == 16'd0);
                        end
                    end else if (w_tmo_hit) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = timeout_q;
    assign err_cnt_o        = err_cnt_q;
    assign word_cnt_o       = word_cnt_q;
    assign first_err_idx_o  = first_err_idx_q;
    assign first_err_data_o = first_err_data_q;

endmodule

`default_nettype wire

// File: tb/tb_gdma_rx_pkt_checker.sv
// ---------------------------------------------------------------------------
// tb_gdma_rx_pkt_checker: directed self-checking bench for gdma_rx_pkt_checker.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gdma_rx_pkt_checker;

    logic        gdma_clk = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        throttle = 1'b0;
    logic [7:0]  pkt_len  = '0;
    logic [31:0] seed     = '0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_cnt;
    logic [7:0]  word_cnt, fe_idx;
    logic [31:0] fe_data;
    logic [31:0] wbuf [8];
    int          checks = 0;
    int          errors = 0;

    gdma_rx_pkt_checker_if axis ();

    gdma_rx_pkt_checker #(
        .LEN_W   (8),
        .TMO_W   (16),
        .TMO_CYC (16'd16)
    ) u_dut (
        .gdma_clk         (gdma_clk),
        .rst_n            (rst_n),
        .start_i          (start),
        .pkt_len_i        (pkt_len),
        .seed_i           (seed),
        .throttle_i       (throttle),
        .s_axis           (axis.slave),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .timeout_o        (timeout),
        .err_cnt_o        (err_cnt),
        .word_cnt_o       (word_cnt),
        .first_err_idx_o  (fe_idx),
        .first_err_data_o (fe_data)
    );

    always #5 gdma_clk = ~gdma_clk;

    task automatic tick();
        @(posedge gdma_clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len, input logic [31:0] s);
        pkt_len = len;
        seed    = s;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic send_words(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            int b;
            b = 0;
            axis.tdata  = wbuf[i];
            axis.tvalid = 1'b1;
            while (!axis.tready && b < 50) begin
                tick();
                b++;
            end
            checks++;
            if (b >= 50) begin
                errors++;
                $display("FAIL send_wait word %0d: tready=0 required 1", i);
            end
            tick();
        end
        axis.tvalid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({busy, done, pass, timeout, axis.tready, err_cnt, word_cnt, fe_idx, fe_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got b%0b d%0b p%0b t%0b r%0b e%h w%h i%h dat%h required all 0",
                     busy, done, pass, timeout, axis.tready, err_cnt, word_cnt, fe_idx, fe_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_pkt();
        do_start(8'd4, 32'h0000_0010);
        wbuf[0] = 32'h10; wbuf[1] = 32'h11; wbuf[2] = 32'h12; wbuf[3] = 32'h13;
        send_words(0, 3);
        checks++;
        if ({busy, done, word_cnt} !== {1'b1, 1'b0, 8'd3}) begin
            errors++;
            $display("FAIL good_mid: got busy=%0b done=%0b wc=%0d required 1 0 3", busy, done, word_cnt);
        end
        send_words(3, 1);
        checks++;
        if ({busy, done, pass, timeout, err_cnt, word_cnt} !== {4'b0110, 16'd0, 8'd4}) begin
            errors++;
            $display("FAIL good_end: got b%0b d%0b p%0b t%0b err=%0d wc=%0d required 0 1 1 0 0 4",
                     busy, done, pass, timeout, err_cnt, word_cnt);
        end
        axis.tvalid = 1'b1;
        axis.tdata  = 32'h14;
        tick(); tick(); tick();
        checks++;
        if ({axis.tready, word_cnt} !== {1'b0, 8'd4}) begin
            errors++;
            $display("FAIL good_excess: got tready=%0b wc=%0d required 0 4", axis.tready, word_cnt);
        end
        axis.tvalid = 1'b0;
    endtask

    task automatic test_mismatch();
        do_start(8'd4, 32'h0);
        wbuf[0] = 32'h0; wbuf[1] = 32'h1; wbuf[2] = 32'h7; wbuf[3] = 32'h3;
        send_words(0, 4);
        checks++;
        if ({done, pass, err_cnt, fe_idx, fe_data} !== {2'b10, 16'd1, 8'd2, 32'h7}) begin
            errors++;
            $display("FAIL mismatch: got d%0b p%0b err=%0d idx=%0d data=%h required 1 0 1 2 00000007",
                     done, pass, err_cnt, fe_idx, fe_data);
        end
    endtask

    task automatic test_multi_err();
        do_start(8'd4, 32'h20);
        wbuf[0] = 32'h20; wbuf[1] = 32'hAA; wbuf[2] = 32'hBB; wbuf[3] = 32'h23;
        send_words(0, 4);
        checks++;
        if ({done, pass, err_cnt, fe_idx, fe_data} !== {2'b10, 16'd2, 8'd1, 32'hAA}) begin
            errors++;
            $display("FAIL multi_err: got d%0b p%0b err=%0d idx=%0d data=%h required 1 0 2 1 000000aa",
                     done, pass, err_cnt, fe_idx, fe_data);
        end
    endtask

    task automatic test_wrap();
        do_start(8'd3, 32'hFFFF_FFFE);
        wbuf[0] = 32'hFFFF_FFFE; wbuf[1] = 32'hFFFF_FFFF; wbuf[2] = 32'h0;
        send_words(0, 3);
        checks++;
        if ({done, pass, err_cnt, word_cnt} !== {2'b11, 16'd0, 8'd3}) begin
            errors++;
            $display("FAIL wrap: got d%0b p%0b err=%0d wc=%0d required 1 1 0 3", done, pass, err_cnt, word_cnt);
        end
    endtask

    task automatic test_throttle();
        int   sent;
        int   bad;
        logic exp_r;
        sent = 0;
        bad  = 0;
        throttle = 1'b1;
        do_start(8'd6, 32'h50);
        for (int c = 0; c < 12; c++) begin
            exp_r = (c % 2 == 0);
            checks++;
            if (axis.tready !== exp_r) begin
                errors++;
                $display("FAIL throttle_ready cycle %0d: got %0b required %0b", c, axis.tready, exp_r);
            end
            axis.tdata  = 32'h50 + 32'(sent);
            axis.tvalid = 1'b1;
            tick();
            if (exp_r) sent++;
        end
        axis.tvalid = 1'b0;
        throttle    = 1'b0;
        checks++;
        if ({done, pass, timeout, word_cnt} !== {3'b110, 8'd6}) begin
            errors++;
            $display("FAIL throttle_end: got d%0b p%0b t%0b wc=%0d required 1 1 0 6", done, pass, timeout, word_cnt);
        end
    endtask

    task automatic test_timeout();
        do_start(8'd5, 32'h0);
        wbuf[0] = 32'h0; wbuf[1] = 32'h1;
        send_words(0, 2);
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if ({busy, timeout} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_early: got busy=%0b timeout=%0b required 1 0", busy, timeout);
        end
        tick();
        checks++;
        if ({busy, done, pass, timeout, word_cnt} !== {4'b0101, 8'd2}) begin
            errors++;
            $display("FAIL timeout_hit: got b%0b d%0b p%0b t%0b wc=%0d required 0 1 0 1 2",
                     busy, done, pass, timeout, word_cnt);
        end
        do_start(8'd0, 32'h0);
        checks++;
        if ({busy, done, pass, timeout, word_cnt} !== {4'b0110, 8'd0}) begin
            errors++;
            $display("FAIL zero_len: got b%0b d%0b p%0b t%0b wc=%0d required 0 1 1 0 0",
                     busy, done, pass, timeout, word_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(8'd8, 32'h100);
        wbuf[0] = 32'h100; wbuf[1] = 32'h101; wbuf[2] = 32'h999;
        send_words(0, 3);
        checks++;
        if ({busy, word_cnt, err_cnt} !== {1'b1, 8'd3, 16'd1}) begin
            errors++;
            $display("FAIL rst_pre: got busy=%0b wc=%0d err=%0d required 1 3 1", busy, word_cnt, err_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, timeout, axis.tready, err_cnt, word_cnt, fe_idx, fe_data} !== '0) begin
            errors++;
            $display("FAIL rst_async: got b%0b d%0b p%0b t%0b r%0b e%h w%h i%h dat%h required all 0",
                     busy, done, pass, timeout, axis.tready, err_cnt, word_cnt, fe_idx, fe_data);
        end
        tick();
        checks++;
        if (axis.tready !== 1'b0) begin
            errors++;
            $display("FAIL rst_tready: got %0b required 0", axis.tready);
        end
        rst_n = 1'b1;
        tick();
        do_start(8'd2, 32'h5);
        wbuf[0] = 32'h5; wbuf[1] = 32'h6;
        send_words(0, 1);
        checks++;
        if ({busy, word_cnt} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL rst_restart_mid: got busy=%0b wc=%0d required 1 1", busy, word_cnt);
        end
        send_words(1, 1);
        checks++;
        if ({done, pass, err_cnt, word_cnt} !== {2'b11, 16'd0, 8'd2}) begin
            errors++;
            $display("FAIL rst_restart_end: got d%0b p%0b err=%0d wc=%0d required 1 1 0 2", done, pass, err_cnt, word_cnt);
        end
    endtask

    initial begin
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        test_reset();
        test_good_pkt();
        test_mismatch();
        test_multi_err();
        test_wrap();
        test_throttle();
        test_timeout();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
